// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage, LSB-first, valid/ready word load
//
// Purpose : accepts an N-bit word on a load_valid/load_ready handshake and emits it
//           LSB-first on ser_out, one bit per clk. A word accepted in the last-bit
//           cycle reloads directly, so back-to-back words stream without gaps.
// Ports   : clk        - clock, rising edge
//           rst        - asynchronous active-high reset
//           din        - parallel word, sampled on accept
//           load_valid - din holds a valid word
//           load_ready - a word can be accepted this cycle
//           ser_out    - serial bit (drives downstream SI)
//           ser_valid  - ser_out carries a frame bit (downstream shift enable)
//           ser_last   - current bit is the final bit of the frame
// Option  : SER_PARITY_EN - append one even-parity bit after the data bits
module piso_serializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_last
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par_q, par_d;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Outputs depend only on registered state; the handshake input only
    // steers next-state, so there is no load_valid -> load_ready path.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
`ifdef SER_PARITY_EN
        par_d      = par_q;
`endif
        load_ready = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                ser_out   = shreg_q[0];
                ser_valid = 1'b1;
                shreg_d   = shreg_q >> 1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef SER_PARITY_EN
                    state_d = PARITY;
`else
                    // Last data bit: open the window for a gapless reload.
                    ser_last   = 1'b1;
                    load_ready = 1'b1;
                    state_d    = IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                ser_out    = par_q;
                ser_valid  = 1'b1;
                ser_last   = 1'b1;
                load_ready = 1'b1;
                state_d    = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accept overrides whatever the current state planned next.
        if (load_valid && load_ready) begin
            shreg_d = din;
            cnt_d   = '0;
            state_d = SHIFT;
`ifdef SER_PARITY_EN
            par_d   = ^din;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized self-checking bench for piso_serializer
module tb_piso_serializer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] din;
    logic         load_valid;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_last;

    piso_serializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: queue of bits still to appear on ser_out; front is the bit
    // shown in the current cycle. Kind: 0 data, 1 last data bit, 2 parity.
    bit           exp_bit[$];
    int           exp_kind[$];
    logic [N-1:0] exp_word[$];
    logic [N-1:0] chain;
    bit           acc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return exp_bit.size() <= 1;
    endfunction

    task automatic push_word(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) begin
            exp_bit.push_back(w[i]);
            exp_kind.push_back(i == N - 1 ? 1 : 0);
        end
`ifdef SER_PARITY_EN
        exp_bit.push_back(^w);
        exp_kind.push_back(2);
`endif
        exp_word.push_back(w);
    endtask

    // One clock: compare at negedge, advance model at posedge, return at posedge+1.
    task automatic cycle();
        bit e_valid, e_out, e_last;
        int kind;
        @(negedge clk);
        e_valid = exp_bit.size() != 0;
        e_out   = e_valid ? exp_bit[0] : 1'b0;
        kind    = e_valid ? exp_kind[0] : 0;
`ifdef SER_PARITY_EN
        e_last  = e_valid && kind == 2;
`else
        e_last  = e_valid && kind == 1;
`endif
        check_eq("load_ready", 32'(load_ready), 32'(model_ready()));
        check_eq("ser_valid",  32'(ser_valid),  32'(e_valid));
        check_eq("ser_out",    32'(ser_out),    32'(e_out));
        check_eq("ser_last",   32'(ser_last),   32'(e_last));
        // Downstream right-shifting register fed by the DUT's serial output.
        if (ser_valid && kind != 2) chain = {ser_out, chain[N-1:1]};
        if (e_valid && kind == 1) check_eq("chain_q", 32'(chain), 32'(exp_word.pop_front()));
        acc = load_valid && model_ready();
        @(posedge clk);
        if (exp_bit.size() != 0) begin
            void'(exp_bit.pop_front());
            void'(exp_kind.pop_front());
        end
        if (acc) push_word(din);
        #1;
    endtask

    task automatic send_held(input logic [N-1:0] w);
        int budget;
        load_valid = 1'b1;
        din        = w;
        budget     = 2 * N + 6;
        acc        = 1'b0;
        while (!acc && budget > 0) begin
            cycle();
            budget--;
        end
        if (!acc) check_eq("accept_timeout", 32'(0), 32'(1));
        load_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        chain      = '0;
        drain(2);
        rst = 1'b0;
        #1;

        // Idle with no request.
        drain(10);

        // Single word.
        send_held(4'b1011);
        drain(N + 3);

        // Back-to-back: second word lands in the final-bit cycle.
        send_held(4'hA);
        send_held(4'h5);
        drain(N + 3);

        // Request pulsed mid-frame is ignored, then a held word gets in.
        send_held(4'hC);
        cycle();
        load_valid = 1'b1;
        din        = 4'h3;
        cycle();
        check_eq("pulse_not_accepted", 32'(acc), 32'(0));
        load_valid = 1'b0;
        cycle();
        send_held(4'h6);
        drain(N + 3);

        // Parity-relevant words.
        send_held(4'b0111);
        send_held(4'h0);
        drain(N + 3);

        // Reset in the middle of a frame.
        send_held(4'hF);
        drain(2);
        rst = 1'b1;
        #1;
        check_eq("rst_ser_valid",  32'(ser_valid),  32'(0));
        check_eq("rst_ser_out",    32'(ser_out),    32'(0));
        check_eq("rst_load_ready", 32'(load_ready), 32'(1));
        exp_bit.delete();
        exp_kind.delete();
        exp_word.delete();
        chain = '0;
        cycle();
        rst = 1'b0;
        #1;
        drain(3);

        // Random traffic; held requests obey the hold-until-accepted rule.
        for (int i = 0; i < 400; i++) begin
            if (!(load_valid && !acc)) begin
                load_valid = ($urandom_range(0, 3) != 0);
                din        = N'($urandom);
            end
            cycle();
        end
        load_valid = 1'b0;
        drain(N + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
